// File: rtl/memio_pkg.sv
// Shared definitions for the memory/IO bus controller: bus command codes,
// FSM state encoding and access latency constants.
package memio_pkg;

  // CPU bus commands; 2'b11 is ignored by the controller
  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  // Cycles from the request being seen in IDLE to the ready pulse
  localparam int unsigned DONE_LAT   = 2;
  // RAM reads spend one extra cycle waiting on the registered RAM output
  localparam int unsigned RAM_RD_LAT = DONE_LAT + 1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StWaitRd = 2'd2,
    StDone   = 2'd3
  } state_e;

  // True for commands that start a transaction
  function automatic logic is_req(input logic [1:0] cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage

// File: rtl/memio_ram.sv
// Single-port RAM with synchronous write and registered (1-cycle) read.
module memio_ram #(
  parameter int unsigned DW        = 16,
  parameter int unsigned AW        = 8,
  parameter              INIT_FILE = ""
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Storage write and registered read of the addressed word
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_io_ctrl.sv
// Memory/IO bus controller. Address MSB=0 selects internal RAM, MSB=1 selects
// memory-mapped IO: output registers first, then synchronised input ports.
// Each access runs through IDLE -> ACCESS -> (WAIT_RD) -> DONE.
// Optional feature: define MEMIO_BUSERR_EN to flag unmapped IO accesses and
// input-port writes on bus_err alongside mem_ready.
module mem_io_ctrl
  import memio_pkg::*;
#(
  parameter int unsigned DW        = 16,
  parameter int unsigned AW        = 9,
  parameter int unsigned NUM_OUT   = 2,
  parameter int unsigned NUM_IN    = 2,
  parameter              INIT_FILE = "data.txt"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mem_cmd,
  input  logic [AW-1:0]         mem_addr,
  input  logic [DW-1:0]         mem_wdata,
  output logic [DW-1:0]         mem_rdata,
  output logic                  mem_ready,
  output logic                  mem_busy,
  output logic [NUM_OUT*DW-1:0] io_out,
  input  logic [NUM_IN*DW-1:0]  io_in,
  output logic                  bus_err
);

  // Width of the RAM word index and of the IO register index
  localparam int unsigned IW = AW - 1;
  localparam logic [IW-1:0] OutLim = IW'(NUM_OUT);
  localparam logic [IW-1:0] InLim  = IW'(NUM_OUT + NUM_IN);

  state_e state_q, state_d;

  logic [1:0]    cmd_q, cmd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] out_q [NUM_OUT];
  logic [DW-1:0] out_d [NUM_OUT];

  logic [NUM_IN*DW-1:0] sync1_q, sync2_q;

  logic [IW-1:0] idx;
  logic          is_ram, is_out, is_in, is_wr;
  logic [DW-1:0] io_rd;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;

  // Decode of the latched request; addr_q is stable from ACCESS through DONE
  assign idx    = addr_q[IW-1:0];
  assign is_ram = ~addr_q[AW-1];
  assign is_out = addr_q[AW-1] && (idx < OutLim);
  assign is_in  = addr_q[AW-1] && (idx >= OutLim) && (idx < InLim);
  assign is_wr  = (cmd_q == MWRITE);

  // IO read mux; unmapped indices read as zero
  always_comb begin
    io_rd = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (idx == IW'(k)) io_rd = out_q[k];
    end
    for (int j = 0; j < NUM_IN; j++) begin
      if (idx == IW'(NUM_OUT + j)) io_rd = sync2_q[j*DW +: DW];
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; mem_cmd is only looked at in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (is_req(mem_cmd)) state_d = StAccess;
      StAccess: state_d = (is_ram && !is_wr) ? StWaitRd : StDone;
      StWaitRd: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    mem_ready = (state_q == StDone);
    mem_busy  = (state_q != StIdle);
    ram_we    = (state_q == StAccess) && is_ram && is_wr;
  end

  // Datapath next state: request capture, IO register writes, read data capture
  always_comb begin
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    for (int k = 0; k < NUM_OUT; k++) out_d[k] = out_q[k];

    if ((state_q == StIdle) && is_req(mem_cmd)) begin
      cmd_d   = mem_cmd;
      addr_d  = mem_addr;
      wdata_d = mem_wdata;
    end

    if (state_q == StAccess) begin
      // Input-port and unmapped writes fall through with no effect
      if (is_out && is_wr) begin
        for (int k = 0; k < NUM_OUT; k++) begin
          if (idx == IW'(k)) out_d[k] = wdata_q;
        end
      end
      if (!is_ram && !is_wr) rdata_d = io_rd;
    end

    if (state_q == StWaitRd) rdata_d = ram_rdata;
  end

  // Datapath registers; reset drops any in-flight write
  always_ff @(posedge clk) begin
    if (!reset) begin
      cmd_q   <= MNONE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      for (int k = 0; k < NUM_OUT; k++) out_q[k] <= '0;
    end else begin
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      for (int k = 0; k < NUM_OUT; k++) out_q[k] <= out_d[k];
    end
  end

  // Two-flop synchroniser on every input-port bit
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= io_in;
      sync2_q <= sync1_q;
    end
  end

  // Flatten output registers onto the io_out bus
  always_comb begin
    io_out = '0;
    for (int k = 0; k < NUM_OUT; k++) io_out[k*DW +: DW] = out_q[k];
  end

  assign mem_rdata = rdata_q;

`ifdef MEMIO_BUSERR_EN
  logic acc_err;
  assign acc_err = addr_q[AW-1] && (!(is_out || is_in) || (is_in && is_wr));
  assign bus_err = mem_ready && acc_err;
`else
  assign bus_err = 1'b0;
`endif

  memio_ram #(
    .DW       (DW),
    .AW       (IW),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .addr_i (addr_q[IW-1:0]),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );

endmodule
